// File: rtl/frame_bank_swap_ctrl_if.sv
// Pixel-write / display-sync bundle between the assembly stage, the
// ping-pong frame-buffer controller and the frame memories.
interface frame_bank_swap_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
);
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic              frame_done;
  logic              disp_vsync;
  logic              wr_en0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              rd_bank;
  logic              frame_ready;
  logic              rx_hold;
  logic              sync_err;
  logic [CNT_W-1:0]  overrun_cnt;

  modport master (
    output pix_we, pix_addr, frame_done, disp_vsync,
    input  wr_en0, wr_en1, wr_addr, wr_bank, rd_bank,
           frame_ready, rx_hold, sync_err, overrun_cnt
  );

  modport slave (
    input  pix_we, pix_addr, frame_done, disp_vsync,
    output wr_en0, wr_en1, wr_addr, wr_bank, rd_bank,
           frame_ready, rx_hold, sync_err, overrun_cnt
  );
endinterface

// File: rtl/frame_bank_swap_ctrl.sv
// Ping-pong frame-buffer bank controller: sequenced pixel fill, vsync swap.
// Optional FILL watchdog enabled by defining FRAME_TIMEOUT_EN.
module frame_bank_swap_ctrl #(
  parameter int FRAME_PIXELS = 40800,
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT_CYC  = 5_000_000,
  parameter int CNT_W        = 8
) (
  input logic                  clk,
  input logic                  reset,
  frame_bank_swap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_C      = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_C       = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] FRAME_END_C = ADDR_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]  CNT_MAX_C   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] exp_addr_r, exp_addr_s;
  logic              accept_s, err_s, swap_s, ovr_inc_s, wd_fire_s;
  logic              wr_en0_r, wr_en1_r, wr_bank_r, rd_bank_r;
  logic              frame_ready_r, sync_err_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [CNT_W-1:0]  overrun_cnt_r;

`ifdef FRAME_TIMEOUT_EN
  localparam int             WD_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST_C = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE_C  = {{(WD_W-1){1'b0}}, 1'b1};

  logic [WD_W-1:0] wd_r, wd_s;

  // Watchdog: counts FILL cycles with no pixel and no frame end; any other cycle clears it.
  always_comb begin
    wd_s      = {WD_W{1'b0}};
    wd_fire_s = 1'b0;
    if ((state_r == FILL) && !bus.pix_we && !bus.frame_done) begin
      if (wd_r == WD_LAST_C) begin
        wd_fire_s = 1'b1;
      end else begin
        wd_s = wd_r + WD_ONE_C;
      end
    end else begin
      wd_s = {WD_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_r <= {WD_W{1'b0}};
    end else begin
      wd_r <= wd_s;
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  // Next-state logic: the pixel is judged first, then frame_done sees the updated count.
  always_comb begin
    state_s    = state_r;
    exp_addr_s = exp_addr_r;
    accept_s   = 1'b0;
    err_s      = 1'b0;
    swap_s     = 1'b0;
    ovr_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.pix_we && (bus.pix_addr == ZERO_C)) begin
          accept_s   = 1'b1;
          exp_addr_s = ONE_C;
          state_s    = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (bus.pix_we) begin
          if ((exp_addr_r != FRAME_END_C) && (bus.pix_addr == exp_addr_r)) begin
            accept_s   = 1'b1;
            exp_addr_s = exp_addr_r + ONE_C;
          end else begin
            err_s      = 1'b1;
            exp_addr_s = ZERO_C;
            state_s    = IDLE;
          end
        end else begin
          state_s = FILL;
        end
        if (bus.frame_done && (state_s == FILL)) begin
          if (exp_addr_s == FRAME_END_C) begin
            state_s = READY;
          end else begin
            err_s      = 1'b1;
            exp_addr_s = ZERO_C;
            state_s    = IDLE;
          end
        end else if (wd_fire_s) begin
          err_s      = 1'b1;
          exp_addr_s = ZERO_C;
          state_s    = IDLE;
        end else begin
          accept_s = accept_s;
        end
      end
      READY: begin
        ovr_inc_s = bus.pix_we;
        if (bus.disp_vsync) begin
          swap_s     = 1'b1;
          exp_addr_s = ZERO_C;
          state_s    = IDLE;
        end else begin
          state_s = READY;
        end
      end
      default: begin
        exp_addr_s = ZERO_C;
        state_s    = IDLE;
      end
    endcase
  end

  // State, bank selection and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      exp_addr_r    <= ZERO_C;
      wr_en0_r      <= 1'b0;
      wr_en1_r      <= 1'b0;
      wr_addr_r     <= ZERO_C;
      wr_bank_r     <= 1'b0;
      rd_bank_r     <= 1'b1;
      frame_ready_r <= 1'b0;
      sync_err_r    <= 1'b0;
      overrun_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      exp_addr_r    <= exp_addr_s;
      wr_en0_r      <= accept_s & ~wr_bank_r;
      wr_en1_r      <= accept_s & wr_bank_r;
      sync_err_r    <= err_s;
      frame_ready_r <= (state_s == READY);
      if (accept_s) begin
        wr_addr_r <= bus.pix_addr;
      end
      // The display always takes the bank just filled, so it is never the write target.
      if (swap_s) begin
        rd_bank_r <= wr_bank_r;
        wr_bank_r <= ~wr_bank_r;
      end
      if (ovr_inc_s && (overrun_cnt_r != CNT_MAX_C)) begin
        overrun_cnt_r <= overrun_cnt_r + CNT_ONE_C;
      end
    end
  end

  assign bus.wr_en0      = wr_en0_r;
  assign bus.wr_en1      = wr_en1_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_bank     = wr_bank_r;
  assign bus.rd_bank     = rd_bank_r;
  assign bus.frame_ready = frame_ready_r;
  assign bus.sync_err    = sync_err_r;
  assign bus.overrun_cnt = overrun_cnt_r;
  assign bus.rx_hold     = (state_r == READY);

endmodule

// File: tb/tb_frame_bank_swap_ctrl.sv
// Directed + randomized bench for frame_bank_swap_ctrl against a behavioural frame model.
module tb_frame_bank_swap_ctrl;

  localparam int FP  = 8;
  localparam int AW  = 16;
  localparam int TO  = 100;
  localparam int CW  = 2;
  localparam int OVR_MAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  frame_bank_swap_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  frame_bank_swap_ctrl #(
    .FRAME_PIXELS(FP),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the frame rules: filling / frame pending, next address, banks, counters.
  bit m_fill, m_ready, m_wbank, m_rbank;
  int m_next, m_ovr, m_wd;
  bit e_wen0, e_wen1, e_err;
  int e_waddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_ready = 0; m_wbank = 0; m_rbank = 1;
    m_next = 0; m_ovr = 0; m_wd = 0;
    e_wen0 = 0; e_wen1 = 0; e_err = 0; e_waddr = 0;
  endtask

  task automatic model_step(input bit we, input int addr, input bit fd, input bit vs);
    bit acc;
    acc   = 0;
    e_err = 0;
    if (m_ready) begin
      if (we && m_ovr < OVR_MAX) m_ovr++;
      if (vs) begin
        m_rbank = m_wbank;
        m_wbank = !m_wbank;
        m_ready = 0;
        m_next  = 0;
      end
    end else if (!m_fill) begin
      if (we && addr == 0) begin
        acc = 1; m_fill = 1; m_next = 1;
      end
    end else begin
      if (we) begin
        if (m_next < FP && addr == m_next) begin
          acc = 1; m_next++;
        end else begin
          e_err = 1; m_fill = 0; m_next = 0;
        end
      end
      if (m_fill && fd) begin
        m_fill = 0;
        if (m_next == FP) m_ready = 1;
        else begin e_err = 1; m_next = 0; end
      end else if (m_fill) begin
        if (acc) m_wd = 0;
        else begin
          m_wd++;
`ifdef FRAME_TIMEOUT_EN
          if (m_wd == TO) begin e_err = 1; m_fill = 0; m_next = 0; end
`endif
        end
      end
    end
    if (!m_fill) m_wd = 0;
    e_wen0 = acc && !m_wbank;
    e_wen1 = acc && m_wbank;
    if (acc) e_waddr = addr;
  endtask

  task automatic compare_all();
    check("wr_en0",      bus.wr_en0,      e_wen0);
    check("wr_en1",      bus.wr_en1,      e_wen1);
    check("wr_addr",     bus.wr_addr,     e_waddr);
    check("wr_bank",     bus.wr_bank,     m_wbank);
    check("rd_bank",     bus.rd_bank,     m_rbank);
    check("frame_ready", bus.frame_ready, m_ready);
    check("rx_hold",     bus.rx_hold,     m_ready);
    check("sync_err",    bus.sync_err,    e_err);
    check("overrun_cnt", bus.overrun_cnt, m_ovr);
  endtask

  task automatic cyc(input bit we, input int addr, input bit fd, input bit vs);
    bus.pix_we     = we;
    bus.pix_addr   = AW'(addr);
    bus.frame_done = fd;
    bus.disp_vsync = vs;
    model_step(we, addr, fd, vs);
    @(posedge clk);
    #1;
    compare_all();
    bus.pix_we     = 1'b0;
    bus.frame_done = 1'b0;
    bus.disp_vsync = 1'b0;
  endtask

  task automatic do_reset(input bit we, input int addr);
    reset          = 1'b0;
    bus.pix_we     = we;
    bus.pix_addr   = AW'(addr);
    bus.frame_done = 1'b0;
    bus.disp_vsync = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_wr_bank", bus.wr_bank, 1'b0);
    check("rst_rd_bank", bus.rd_bank, 1'b1);
    check("rst_wr_en",   {bus.wr_en1, bus.wr_en0}, 2'b00);
    check("rst_flags",   {bus.frame_ready, bus.rx_hold, bus.sync_err}, 3'b000);
    check("rst_ovr",     bus.overrun_cnt, 2'd0);
    bus.pix_we = 1'b0;
    reset      = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.pix_we = 1'b0; bus.pix_addr = '0; bus.frame_done = 1'b0; bus.disp_vsync = 1'b0;

    do_reset(1'b0, 0);

    // Full frame into bank 0, then frame_done.
    for (int i = 0; i < FP; i++) begin
      cyc(1'b1, i, 1'b0, 1'b0);
      check("f0_wen0", bus.wr_en0, 1'b1);
      check("f0_addr", bus.wr_addr, i);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("f0_ready", {bus.frame_ready, bus.rx_hold, bus.rd_bank}, 3'b111);

    // Swap on vsync.
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("swap1", {bus.rd_bank, bus.wr_bank, bus.frame_ready, bus.rx_hold}, 4'b0100);

    // Frame into bank 1; last pixel arrives with frame_done.
    for (int i = 0; i < FP; i++) begin
      cyc(1'b1, i, (i == FP - 1), 1'b0);
      check("f1_wen", {bus.wr_en1, bus.wr_en0}, 2'b10);
    end
    check("f1_ready", bus.frame_ready, 1'b1);

    // Overruns while a frame waits, saturating at 3.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, i, 1'b0, 1'b0);
      check("ovr_nowen", {bus.wr_en1, bus.wr_en0, bus.sync_err}, 3'b000);
      check("ovr_cnt", bus.overrun_cnt, (i > 3) ? 3 : i);
    end
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("swap2", {bus.rd_bank, bus.wr_bank}, 2'b10);

    // Out-of-sequence address aborts the frame, then a clean frame.
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0);
    check("seq_err", {bus.sync_err, bus.wr_en0}, 2'b10);
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("seq_err_pulse", bus.sync_err, 1'b0);
    for (int i = 0; i < FP; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("recover_ready", bus.frame_ready, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Stalled fill: watchdog abort only when the feature is built in.
    for (int i = 0; i < 4; i++) cyc(1'b1, i, 1'b0, 1'b0);
`ifdef FRAME_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      check("wd_err", bus.sync_err, (i == TO));
    end
`else
    for (int i = 1; i <= 2 * TO; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      check("no_wd_err", bus.sync_err, 1'b0);
    end
`endif
    check("wd_bank", bus.wr_bank, 1'b1);

    // Reset mid-fill with a write strobe present.
    do_reset(1'b0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, i, 1'b0, 1'b0);
    do_reset(1'b1, 4);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit we, fd, vs;
      int addr, exp_a;
      exp_a = m_fill ? m_next : 0;
      we    = ($urandom_range(0, 99) < 70);
      addr  = ($urandom_range(0, 99) < 92) ? exp_a : int'($urandom_range(0, 9));
      fd    = (m_next == FP) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 2);
      vs    = ($urandom_range(0, 99) < 8);
      cyc(we, addr, fd, vs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
